// File: rtl/decode_stage.sv
// Decode stage: splits instruction fields, reads operands through
// req/ack register ports and blocks on RAW hazards via a scoreboard.
module decode_stage #(
  parameter int WIDTH        = 32,
  parameter int REG_ADDR_LEN = 5,
  parameter int PC_WIDTH     = WIDTH - 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        ir_in,
  input  logic [PC_WIDTH-1:0]     pc_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        ir_out,
  output logic [PC_WIDTH-1:0]     pc_out,
  output logic [WIDTH-1:0]        x,
  output logic [WIDTH-1:0]        y,
  output logic [REG_ADDR_LEN-1:0] dst,
  output logic                    illegal,
  output logic [REG_ADDR_LEN-1:0] rd1_addr,
  output logic [REG_ADDR_LEN-1:0] rd2_addr,
  output logic                    rd1_en,
  output logic                    rd2_en,
  input  logic [WIDTH-1:0]        rd1_data,
  input  logic [WIDTH-1:0]        rd2_data,
  input  logic                    rd1_ack,
  input  logic                    rd2_ack,
  input  logic                    wb_en,
  input  logic [REG_ADDR_LEN-1:0] wb_addr,
  input  logic                    flush
);

  localparam int NREG = 2 ** REG_ADDR_LEN;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_R    = 6'h01;
  localparam logic [5:0] OP_I    = 6'h02;
  localparam logic [5:0] OP_BR   = 6'h03;
  localparam logic [5:0] OP_J    = 6'h04;
  localparam logic [5:0] OP_HALT = 6'h05;

  localparam logic [WIDTH-1:0] NOP_IR = '0;

  logic [1:0]              state_q, state_d;
  logic [WIDTH-1:0]        ir_q, ir_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [WIDTH-1:0]        x_q, x_d;
  logic [WIDTH-1:0]        y_q, y_d;
  logic [NREG-1:0]         sb_q, sb_d;
  logic                    rd1_en_q, rd1_en_d;
  logic                    rd2_en_q, rd2_en_d;
  logic [REG_ADDR_LEN-1:0] rd1_addr_q, rd1_addr_d;
  logic [REG_ADDR_LEN-1:0] rd2_addr_q, rd2_addr_d;

  logic [5:0]              opc;
  logic [REG_ADDR_LEN-1:0] f_rd, f_rs, f_rt, src1, dst_w;
  logic [15:0]             imm;
  logic [25:0]             tgt;
  logic [WIDTH-1:0]        sext, zext;
  logic is_r, is_i, is_br, is_j, is_ill;
  logic need1, need2, hazard, fire;

  assign opc  = ir_q[31:26];
  assign f_rd = REG_ADDR_LEN'(ir_q[25:21]);
  assign f_rs = REG_ADDR_LEN'(ir_q[20:16]);
  assign f_rt = REG_ADDR_LEN'(ir_q[15:11]);
  assign imm  = ir_q[15:0];
  assign tgt  = ir_q[25:0];
  assign sext = {{(WIDTH-16){imm[15]}}, imm};
  assign zext = {{(WIDTH-26){1'b0}}, tgt};

  always_comb begin
    is_r   = 1'b0;
    is_i   = 1'b0;
    is_br  = 1'b0;
    is_j   = 1'b0;
    is_ill = 1'b0;
    unique case (1'b1)
      (opc == OP_R):  is_r  = 1'b1;
      (opc == OP_I):  is_i  = 1'b1;
      (opc == OP_BR): is_br = 1'b1;
      (opc == OP_J):  is_j  = 1'b1;
      (opc == OP_NOP),
      (opc == OP_HALT): ;
      default: is_ill = 1'b1;
    endcase
  end

  // Branches compare against R[Rd], so Rd feeds port 1 instead of Rs.
  assign src1   = is_br ? f_rd : f_rs;
  assign need1  = (is_r | is_i | is_br) & (src1 != '0);
  assign need2  = is_r & (f_rt != '0);
  assign hazard = (need1 & sb_q[src1]) | (need2 & sb_q[f_rt]);
  assign dst_w  = (is_r | is_i) ? f_rd : '0;
  assign fire   = (state_q == S_OUT) & out_ready & ~flush;

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    x_d        = x_q;
    y_d        = y_q;
    rd1_en_d   = rd1_en_q;
    rd2_en_d   = rd2_en_q;
    rd1_addr_d = rd1_addr_q;
    rd2_addr_d = rd2_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          ir_d    = ir_in;
          pc_d    = pc_in;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!hazard) begin
          x_d        = is_j ? zext : '0;
          y_d        = (is_i | is_br) ? sext : '0;
          rd1_en_d   = need1;
          rd2_en_d   = need2;
          rd1_addr_d = need1 ? src1 : '0;
          rd2_addr_d = need2 ? f_rt : '0;
          state_d    = (need1 | need2) ? S_READ : S_OUT;
        end
      end
      S_READ: begin
        if (rd1_en_q && rd1_ack) begin
          x_d      = rd1_data;
          rd1_en_d = 1'b0;
        end
        if (rd2_en_q && rd2_ack) begin
          y_d      = rd2_data;
          rd2_en_d = 1'b0;
        end
        if (!rd1_en_d && !rd2_en_d) state_d = S_OUT;
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
    endcase
    if (flush) begin
      state_d  = S_IDLE;
      ir_d     = NOP_IR;
      x_d      = '0;
      y_d      = '0;
      rd1_en_d = 1'b0;
      rd2_en_d = 1'b0;
    end
  end

  // A retire and a new claim on the same register: the claim must win.
  always_comb begin
    sb_d = sb_q;
    if (wb_en) sb_d[wb_addr] = 1'b0;
    if (fire && dst_w != '0) sb_d[dst_w] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ir_q       <= NOP_IR;
      pc_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sb_q       <= '0;
      rd1_en_q   <= 1'b0;
      rd2_en_q   <= 1'b0;
      rd1_addr_q <= '0;
      rd2_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sb_q       <= sb_d;
      rd1_en_q   <= rd1_en_d;
      rd2_en_q   <= rd2_en_d;
      rd1_addr_q <= rd1_addr_d;
      rd2_addr_q <= rd2_addr_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) & rst_n;
  assign out_valid = (state_q == S_OUT);
  assign ir_out    = ir_q;
  assign pc_out    = pc_q;
  assign x         = x_q;
  assign y         = y_q;
  assign dst       = dst_w;
  assign illegal   = is_ill;
  assign rd1_en    = rd1_en_q;
  assign rd2_en    = rd2_en_q;
  assign rd1_addr  = rd1_addr_q;
  assign rd2_addr  = rd2_addr_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: vector table, directed corner sequences
// and random instructions against a field-level reference model.
module tb_decode_stage;

  localparam int W = 32;
  localparam int A = 5;
  localparam int P = 30;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_R    = 6'h01;
  localparam logic [5:0] OP_I    = 6'h02;
  localparam logic [5:0] OP_BR   = 6'h03;
  localparam logic [5:0] OP_J    = 6'h04;
  localparam logic [5:0] OP_HALT = 6'h05;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] ir_in = '0;
  logic [P-1:0] pc_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] ir_out;
  logic [P-1:0] pc_out;
  logic [W-1:0] x, y;
  logic [A-1:0] dst;
  logic         illegal;
  logic [A-1:0] rd1_addr, rd2_addr;
  logic         rd1_en, rd2_en;
  logic [W-1:0] rd1_data = '0;
  logic [W-1:0] rd2_data = '0;
  logic         rd1_ack = 1'b0;
  logic         rd2_ack = 1'b0;
  logic         wb_en = 1'b0;
  logic [A-1:0] wb_addr = '0;
  logic         flush = 1'b0;

  decode_stage #(.WIDTH(W), .REG_ADDR_LEN(A), .PC_WIDTH(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .ir_in(ir_in), .pc_in(pc_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .ir_out(ir_out), .pc_out(pc_out),
    .x(x), .y(y), .dst(dst), .illegal(illegal),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_en(rd1_en), .rd2_en(rd2_en),
    .rd1_data(rd1_data), .rd2_data(rd2_data),
    .rd1_ack(rd1_ack), .rd2_ack(rd2_ack),
    .wb_en(wb_en), .wb_addr(wb_addr),
    .flush(flush)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] regs [32];
  bit busy [32];
  int dly1 = 0, dly2 = 0, w1 = 0, w2 = 0, p1 = 0, p2 = 0;
  bit auto_ack = 1'b1;

  typedef struct {
    logic [31:0] ir;
    int d1, d2;
    logic [31:0] ex, ey;
    logic [4:0] ed;
    logic ei;
    int lat, p1, p2;
  } vec_t;
  vec_t vec [11];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Register-file responder: acks after dlyN cycles of rdN_en.
  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_ack) begin
      if (rd1_en) begin
        rd1_ack  = (w1 >= dly1);
        rd1_data = regs[rd1_addr];
        w1++;
        p1++;
      end else begin
        rd1_ack = 1'b0;
        w1 = 0;
      end
      if (rd2_en) begin
        rd2_ack  = (w2 >= dly2);
        rd2_data = regs[rd2_addr];
        w2++;
        p2++;
      end else begin
        rd2_ack = 1'b0;
        w2 = 0;
      end
    end
  endtask

  function automatic logic [31:0] mk_r(input logic [5:0] op,
    input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rd, rs, rt, 11'h0};
  endfunction

  function automatic logic [31:0] mk_i(input logic [5:0] op,
    input logic [4:0] rd, input logic [4:0] rs, input logic [15:0] im);
    return {op, rd, rs, im};
  endfunction

  function automatic void model(input logic [31:0] ir,
    output logic [31:0] ex, output logic [31:0] ey,
    output logic [4:0] ed, output logic ei,
    output int a1, output int a2);
    logic [31:0] simm;
    simm = ir[15] ? (32'hFFFF0000 | {16'h0, ir[15:0]})
                  : {16'h0, ir[15:0]};
    ex = '0; ey = '0; ed = '0; ei = 1'b0; a1 = -1; a2 = -1;
    case (ir[31:26])
      OP_R:  begin a1 = ir[20:16]; a2 = ir[15:11]; ed = ir[25:21]; end
      OP_I:  begin a1 = ir[20:16]; ey = simm; ed = ir[25:21]; end
      OP_BR: begin a1 = ir[25:21]; ey = simm; end
      OP_J:  ex = {6'h0, ir[25:0]};
      OP_NOP, OP_HALT: ;
      default: ei = 1'b1;
    endcase
    if (a1 == 0) a1 = -1;
    if (a2 == 0) a2 = -1;
    if (a1 >= 0) ex = regs[a1];
    if (a2 >= 0) ey = regs[a2];
  endfunction

  task automatic issue(input logic [31:0] ir, input logic [29:0] pc);
    int g = 0;
    while (!in_ready && g < 50) begin
      tick();
      g++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    p1 = 0;
    p2 = 0;
    ir_in = ir;
    pc_in = pc;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int c = 0;
    while (!out_valid && c < 60) begin
      tick();
      c++;
    end
    if (!out_valid) check("out_valid_timeout", 0, 1);
    lat = c + 1;
  endtask

  task automatic fire(input logic [4:0] d);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    if (d != 0) busy[d] = 1'b1;
  endtask

  task automatic pulse_wb(input logic [4:0] a);
    wb_en = 1'b1;
    wb_addr = a;
    tick();
    wb_en = 1'b0;
    busy[a] = 1'b0;
  endtask

  task automatic stall_check(input string name, input int n);
    bit bad = 1'b0;
    repeat (n) begin
      tick();
      bad |= rd1_en | rd2_en | out_valid;
    end
    check(name, 64'(bad), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic [31:0] ex, ey, hx;
    logic [4:0] ed;
    logic ei;
    int a1, a2;

    for (int i = 0; i < 32; i++) begin
      regs[i] = $urandom;
      busy[i] = 1'b0;
    end
    regs[3] = 32'h10;
    regs[4] = 32'h20;
    regs[7] = 32'hDEADBEEF;
    regs[9] = 32'h80000001;

    vec[0]  = '{mk_r(OP_R, 6, 3, 4), 0, 0, 32'h10, 32'h20,
                5'd6, 1'b0, 3, 1, 1};
    vec[1]  = '{mk_i(OP_I, 8, 7, 16'hFFFE), 0, 0, 32'hDEADBEEF,
                32'hFFFFFFFE, 5'd8, 1'b0, 3, 1, 0};
    vec[2]  = '{{OP_J, 26'h3FFFFFF}, 0, 0, 32'h03FFFFFF, 32'h0,
                5'd0, 1'b0, 2, 0, 0};
    vec[3]  = '{32'h0, 0, 0, 32'h0, 32'h0, 5'd0, 1'b0, 2, 0, 0};
    vec[4]  = '{mk_i(OP_BR, 9, 2, 16'h7FFF), 0, 0, 32'h80000001,
                32'h00007FFF, 5'd0, 1'b0, 3, 1, 0};
    vec[5]  = '{32'hFC631234, 0, 0, 32'h0, 32'h0, 5'd0, 1'b1, 2, 0, 0};
    vec[6]  = '{mk_r(OP_R, 2, 0, 4), 0, 0, 32'h0, 32'h20,
                5'd2, 1'b0, 3, 0, 1};
    vec[7]  = '{mk_r(OP_R, 5, 0, 0), 0, 0, 32'h0, 32'h0,
                5'd5, 1'b0, 2, 0, 0};
    vec[8]  = '{mk_i(OP_I, 10, 3, 16'h0005), 2, 0, 32'h10, 32'h5,
                5'd10, 1'b0, 5, 3, 0};
    vec[9]  = '{mk_r(OP_R, 11, 9, 7), 1, 3, 32'h80000001, 32'hDEADBEEF,
                5'd11, 1'b0, 6, 2, 4};
    vec[10] = '{{OP_HALT, 26'h155}, 0, 0, 32'h0, 32'h0,
                5'd0, 1'b0, 2, 0, 0};

    // reset state
    repeat (2) @(posedge clk);
    #2;
    check("rst_in_ready", 64'(in_ready), 0);
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_ir_out", 64'(ir_out), 0);
    check("rst_bundle", {pc_out, dst, illegal}, 0);
    check("rst_xy", {x, y}, 0);
    check("rst_rd", {rd1_en, rd2_en, rd1_addr, rd2_addr}, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 1);

    // vector table
    for (int i = 0; i < 11; i++) begin
      dly1 = vec[i].d1;
      dly2 = vec[i].d2;
      issue(vec[i].ir, 30'(i * 4 + 1));
      wait_out(lat);
      check($sformatf("v%0d_x", i), 64'(x), 64'(vec[i].ex));
      check($sformatf("v%0d_y", i), 64'(y), 64'(vec[i].ey));
      check($sformatf("v%0d_dst", i), 64'(dst), 64'(vec[i].ed));
      check($sformatf("v%0d_ill", i), 64'(illegal), 64'(vec[i].ei));
      check($sformatf("v%0d_lat", i), 64'(lat), 64'(vec[i].lat));
      check($sformatf("v%0d_pc", i), 64'(pc_out), 64'(i * 4 + 1));
      check($sformatf("v%0d_ir", i), 64'(ir_out), 64'(vec[i].ir));
      check($sformatf("v%0d_p1", i), 64'(p1), 64'(vec[i].p1));
      check($sformatf("v%0d_p2", i), 64'(p2), 64'(vec[i].p2));
      fire(vec[i].ed);
      check($sformatf("v%0d_idle", i), {in_ready, out_valid}, 2'b10);
      if (vec[i].ed != 0) pulse_wb(vec[i].ed);
    end
    dly1 = 0;
    dly2 = 0;

    // RAW hazard and release by writeback
    issue(mk_i(OP_I, 5, 3, 16'h1), 30'h100);
    wait_out(lat);
    fire(5);
    issue(mk_r(OP_R, 13, 5, 4), 30'h101);
    stall_check("raw_stall", 4);
    wb_en = 1'b1;
    wb_addr = 5;
    tick();
    wb_en = 1'b0;
    busy[5] = 1'b0;
    check("raw_wb_edge_en", 64'(rd1_en), 0);
    tick();
    check("raw_read_start", {rd1_en, rd2_en}, 2'b11);
    wait_out(lat);
    check("raw_x", 64'(x), 64'(regs[5]));
    check("raw_y", 64'(y), 32'h20);

    // same-cycle fire and retire of R13: claim must survive
    wb_en = 1'b1;
    wb_addr = 13;
    out_ready = 1'b1;
    tick();
    wb_en = 1'b0;
    out_ready = 1'b0;
    busy[13] = 1'b1;
    issue(mk_r(OP_R, 18, 13, 0), 30'h102);
    stall_check("setwins_stall", 4);
    pulse_wb(13);
    wait_out(lat);
    check("setwins_x", 64'(x), 64'(regs[13]));
    fire(18);
    pulse_wb(18);

    // backpressure
    issue(mk_r(OP_R, 12, 3, 4), 30'h103);
    wait_out(lat);
    begin
      bit bad = 1'b0;
      repeat (4) begin
        tick();
        bad |= (out_valid !== 1'b1) | (in_ready !== 1'b0);
        bad |= (x !== 32'h10) | (y !== 32'h20) | (dst !== 5'd12);
        bad |= (pc_out !== 30'h103);
      end
      check("bp_hold", 64'(bad), 0);
    end
    fire(12);
    issue(mk_r(OP_R, 17, 12, 0), 30'h104);
    stall_check("bp_sb_set", 3);
    pulse_wb(12);
    wait_out(lat);
    check("bp_after_x", 64'(x), 64'(regs[12]));
    fire(17);
    pulse_wb(17);

    // flush in READ with rd2 ack outstanding
    dly2 = 10;
    issue(mk_r(OP_R, 14, 3, 4), 30'h105);
    tick();
    tick();
    check("fr_pending", {rd1_en, rd2_en}, 2'b01);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dly2 = 0;
    check("fr_state", {out_valid, rd1_en, rd2_en, in_ready}, 4'b0001);
    check("fr_ir", 64'(ir_out), 0);
    issue(mk_r(OP_R, 19, 14, 0), 30'h106);
    wait_out(lat);
    check("fr_no_sb_lat", 64'(lat), 3);
    check("fr_no_sb_x", 64'(x), 64'(regs[14]));
    fire(19);
    pulse_wb(19);

    // flush coinciding with out_ready
    issue(mk_i(OP_I, 15, 3, 16'h2), 30'h107);
    wait_out(lat);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    out_ready = 1'b0;
    check("fo_state", {out_valid, in_ready}, 2'b01);
    check("fo_ir", 64'(ir_out), 0);
    issue(mk_r(OP_R, 20, 15, 0), 30'h108);
    wait_out(lat);
    check("fo_no_sb_lat", 64'(lat), 3);
    fire(20);
    pulse_wb(20);

    // illegal opcode cleared by flush
    issue({6'h3F, 26'h1234567}, 30'h109);
    wait_out(lat);
    check("ill_flag", 64'(illegal), 1);
    check("ill_xy", {x, y, dst}, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ill_flushed", 64'(illegal), 0);

    // async reset in the middle of READ
    auto_ack = 1'b0;
    rd1_ack = 1'b0;
    rd2_ack = 1'b0;
    issue(mk_i(OP_I, 16, 3, 16'h1), 30'h10A);
    tick();
    check("mr_reading", 64'(rd1_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_rst", {rd1_en, out_valid, in_ready}, 3'b000);
    check("mr_ir", 64'(ir_out), 0);
    tick();
    rst_n = 1'b1;
    rd1_ack = 1'b1;
    rd2_ack = 1'b1;
    tick();
    rd1_ack = 1'b0;
    rd2_ack = 1'b0;
    check("mr_late_ack", {rd1_en, out_valid, in_ready}, 3'b001);
    check("mr_late_x", 64'(x), 0);
    auto_ack = 1'b1;
    for (int i = 0; i < 32; i++) busy[i] = 1'b0;

    // randomized instructions against the model
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ir;
      logic [5:0] op;
      int r, mx, elat;
      bit haz, bad;
      r = $urandom_range(0, 7);
      op = (r < 6) ? 6'(r) : 6'($urandom_range(6, 63));
      ir = {op, 26'($urandom)};
      dly1 = $urandom_range(0, 2);
      dly2 = $urandom_range(0, 2);
      model(ir, ex, ey, ed, ei, a1, a2);
      haz = (a1 >= 0 && busy[a1]) || (a2 >= 0 && busy[a2]);
      mx = 0;
      if (a1 >= 0) mx = dly1;
      if (a2 >= 0 && dly2 > mx) mx = dly2;
      elat = (a1 >= 0 || a2 >= 0) ? 3 + mx : 2;
      issue(ir, 30'($urandom));
      if (haz) begin
        stall_check($sformatf("r%0d_stall", n), 3);
        if (a1 >= 0 && busy[a1]) pulse_wb(5'(a1));
        if (a2 >= 0 && busy[a2]) pulse_wb(5'(a2));
      end
      wait_out(lat);
      if (!haz) check($sformatf("r%0d_lat", n), 64'(lat), 64'(elat));
      check($sformatf("r%0d_x", n), 64'(x), 64'(ex));
      check($sformatf("r%0d_y", n), 64'(y), 64'(ey));
      check($sformatf("r%0d_dst_ill", n), {dst, illegal}, {ed, ei});
      hx = x;
      bad = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        tick();
        bad |= (out_valid !== 1'b1) | (x !== hx) | (in_ready !== 1'b0);
      end
      check($sformatf("r%0d_hold", n), 64'(bad), 0);
      fire(ed);
      if ($urandom_range(0, 1) == 1) pulse_wb(5'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised instruction-decode stage between fetch and execute. It accepts one instruction word plus PC per handshake, splits the ISA fields, and fetches source operands from the register file through request/acknowledge read ports. It blocks on read-after-write hazards using an internal pending-write scoreboard and presents decoded operands X/Y downstream with a valid/ready handshake. Flush support discards in-flight work without corrupting hazard state.

## Interface
- `WIDTH`, 32, datapath and instruction width (≥32).
- `REG_ADDR_LEN`, 5, register address width; scoreboard has 2^REG_ADDR_LEN bits.
- `PC_WIDTH`, WIDTH-2, word-address PC width.
- `clk` in 1, single clock, all state on rising edge.
- `rst_n` in 1, asynchronous active-low reset.
- `in_valid` in 1, `in_ready` out 1, `ir_in` in WIDTH, `pc_in` in PC_WIDTH: upstream instruction handshake.
- `out_valid` out 1, `out_ready` in 1: downstream handshake.
- `ir_out` out WIDTH, `pc_out` out PC_WIDTH, `x` out WIDTH, `y` out WIDTH, `dst` out REG_ADDR_LEN, `illegal` out 1: decoded bundle.
- `rd1_addr`/`rd2_addr` out REG_ADDR_LEN, `rd1_en`/`rd2_en` out 1, `rd1_data`/`rd2_data` in WIDTH, `rd1_ack`/`rd2_ack` in 1: register read ports.
- `wb_en` in 1, `wb_addr` in REG_ADDR_LEN: writeback retire, clears scoreboard bit.
- `flush` in 1: kill in-flight instruction.

## Operation
- Fields: opcode [31:26], Rd [25:21], Rs [20:16], Rt [15:11], Imm [15:0], Tgt [25:0].
- Per opcode class (ISA macros):
  - R_TYPE: x=R[Rs], y=R[Rt], dst=Rd.
  - I_TYPE: x=R[Rs], y=sext(Imm), dst=Rd.
  - Branch: x=R[Rd], y=sext(Imm), dst=0.
  - J_TYPE: x=zext(Tgt), y=0, dst=0.
  - NOP/HALT: x=y=0, dst=0.
  - Any other opcode: handled as NOP with `illegal`=1.
- sext: replicate Imm[15] to WIDTH. zext: upper WIDTH-26 bits zero.
- Register 0: sources read as 0 with no port request and never hazard; dst=0 never marks the scoreboard.
- FSM:
  - IDLE: `in_ready`=1. On in_valid & ~flush, latch ir/pc → CHECK.
  - CHECK: if any needed nonzero source has its scoreboard bit set, stay. Else go to READ if any port is needed, otherwise OUT.
  - READ: `rdN_en`=1 held for each needed port until its ack is sampled; data is captured on the ack edge and the en drops the next cycle. When all needed ports are captured → OUT.
  - OUT: `out_valid`=1, bundle stable. On out_valid & out_ready & ~flush (fire) → IDLE; set scoreboard[dst] if dst≠0.
- Scoreboard: same-cycle set and wb clear of one address → set wins. wb_en for a clear bit is harmless.
- Acks with rdN_en low are ignored.
- flush (any state): next state IDLE, rdN_en=0, out_valid=0, ir_out←NOP, illegal←0. No scoreboard set; wb clears still apply. Flush beats in_valid and out_ready in the same cycle.

## Timing
- Reset (async): state IDLE, scoreboard all 0. ir_out=NOP; pc_out, x, y, dst, illegal, out_valid, rdN_en, rdN_addr=0. in_ready=0 while rst_n low.
- in_ready and out_valid are decoded from registered state; out_ready, ack and flush have no combinational path to any output except through state.
- Latency from accept edge to out_valid high:
  - 2 cycles with no reads.
  - 3 cycles with reads acked in their first en cycle.
  - Plus one cycle per hazard-stall cycle and per ack-wait cycle.
- Throughput: at most one instruction per 3 cycles, since in_ready is low outside IDLE.
- A wb_en clear sampled at edge k lets CHECK leave at edge k+1.
- Port acks may arrive in different cycles; each is captured independently.

## Test plan
- Reset mid-READ (rd1_en=1): rst_n low → rd1_en=0, out_valid=0, ir_out=NOP immediately. A later ack is ignored.
- R_TYPE Rs=3, Rt=4 with R3=0x10 and R4=0x20, both acked in their first en cycle → x=0x10, y=0x20, dst=Rd, out_valid 3 cycles after accept. Fire sets scoreboard[Rd].
- I_TYPE Imm=0xFFFE → y=0xFFFFFFFE. J_TYPE Tgt=0x3FFFFFF → x=0x03FFFFFF, y=0, no rd_en pulses. NOP → out_valid 2 cycles after accept.
- RAW hazard: issue I_TYPE dst=5, then R_TYPE Rs=5 → stays in CHECK, rd_en low. Pulse wb_en with wb_addr=5 → reads start the next cycle. Same-cycle wb clear and new set of R5 → bit remains set.
- Backpressure: out_ready low 4 cycles in OUT → bundle stable, in_ready=0, scoreboard unchanged until fire.
- Flush in READ with rd2 ack pending, and flush coinciding with out_ready in OUT → IDLE next cycle, ir_out=NOP, no scoreboard set. Illegal opcode 0x3F → illegal=1, x=y=0.
